// File: rtl/soft_start_ramp.sv
// Soft-start duty ramp with period-aligned updates, steady-state slew limiting and fault latch.
// Optional watchdog on a stalled DPWM: define SOFT_START_TIMEOUT_EN.
module soft_start_ramp #(
  parameter int unsigned DW               = 10,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned TIMEOUT_CYC      = 4096
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [DW-1:0] duty_target,
  input  logic [DW-1:0] maxcount,
  input  logic          period_start,
  input  logic [3:0]    ramp_step,
  input  logic          fault_in,
  input  logic          fault_clr,
  output logic [DW-1:0] adj_duty,
  output logic          pwm_en,
  output logic          ramp_done,
  output logic          fault_latched,
`ifdef SOFT_START_TIMEOUT_EN
  output logic          timeout_flag,
`endif
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRamp  = 2'b01,
    StRun   = 2'b10,
    StFault = 2'b11
  } state_e;

  localparam int unsigned DivW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PERIODS_PER_STEP - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] adj_q, adj_d;
  logic          pwm_en_q, pwm_en_d;
  logic          ramp_done_q;
  logic          fault_q;
  logic [DivW-1:0] div_q, div_d;

  logic [DW-1:0] eff_target;
  logic [DW:0]   step;
  logic [DW:0]   sum;
  logic          sum_reaches;
  logic          force_fault;

  assign eff_target  = (duty_target < maxcount) ? duty_target : maxcount;
  assign step        = (ramp_step == 4'd0) ? (DW+1)'(1) : (DW+1)'(ramp_step);
  // Widened so a large step near full scale saturates instead of wrapping.
  assign sum         = {1'b0, adj_q} + step;
  assign sum_reaches = (sum >= {1'b0, eff_target});

`ifdef SOFT_START_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
  logic           wd_active;
  logic           timeout_hit;

  assign wd_active   = (state_q == StRamp) || (state_q == StRun);
  assign timeout_hit = wd_active && !period_start && (wd_q == WdLast);
  assign force_fault = fault_in || timeout_hit;

  always_comb begin
    wd_d      = '0;
    timeout_d = timeout_q;
    if (wd_active && !period_start && !timeout_hit) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout_hit) begin
      timeout_d = 1'b1;
    end else if (state_q == StFault && state_d == StIdle) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign force_fault = fault_in;
`endif

  always_comb begin
    state_d  = state_q;
    adj_d    = adj_q;
    pwm_en_d = pwm_en_q;
    div_d    = div_q;

    if (force_fault) begin
      state_d  = StFault;
      adj_d    = '0;
      pwm_en_d = 1'b0;
      div_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          adj_d    = '0;
          pwm_en_d = 1'b0;
          div_d    = '0;
          if (en) begin
            state_d  = StRamp;
            pwm_en_d = 1'b1;
          end
        end
        StRamp: begin
          if (!en) begin
            state_d  = StIdle;
            adj_d    = '0;
            pwm_en_d = 1'b0;
            div_d    = '0;
          end else if (period_start) begin
            if (div_q == DivLast) begin
              div_d = '0;
              // Also covers a target that fell below the current duty.
              if (sum_reaches) begin
                adj_d   = eff_target;
                state_d = StRun;
              end else begin
                adj_d = sum[DW-1:0];
              end
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (!en) begin
            state_d  = StIdle;
            adj_d    = '0;
            pwm_en_d = 1'b0;
            div_d    = '0;
          end else if (period_start) begin
            adj_d = sum_reaches ? eff_target : sum[DW-1:0];
          end
        end
        StFault: begin
          adj_d    = '0;
          pwm_en_d = 1'b0;
          div_d    = '0;
          if (fault_clr && !en) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d  = StIdle;
          adj_d    = '0;
          pwm_en_d = 1'b0;
          div_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      adj_q       <= '0;
      pwm_en_q    <= 1'b0;
      ramp_done_q <= 1'b0;
      fault_q     <= 1'b0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      adj_q       <= adj_d;
      pwm_en_q    <= pwm_en_d;
      ramp_done_q <= (state_d == StRun);
      fault_q     <= (state_d == StFault);
      div_q       <= div_d;
    end
  end

  assign state         = state_q;
  assign adj_duty      = adj_q;
  assign pwm_en        = pwm_en_q;
  assign ramp_done     = ramp_done_q;
  assign fault_latched = fault_q;

endmodule
